// File: rtl/key_event_queue.sv
// key_event_queue
// Turns debounced active-low key levels into PRESS / REPEAT / RELEASE events.
// Each key has a hold-to-repeat FSM and a one-entry pending slot. A fixed-priority
// arbiter moves pending events into a small FWFT FIFO that the consumer drains
// over a valid/ready handshake.
// Optional feature: define KEY_RELEASE_EVT_EN to queue RELEASE events. Without it,
// releases still stop auto-repeat but produce no event.
//
// Key FSM states:
//   state    | meaning
//   S_IDLE   | key released, waiting for a press edge
//   S_DELAY  | key held, counting down to the first REPEAT
//   S_REPEAT | key held, emitting a REPEAT every REPEAT_PERIOD cycles
module key_event_queue #(
  parameter int NUM_KEYS      = 4,
  parameter int HOLD_DELAY    = 25000000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter int FIFO_DEPTH    = 4,
  localparam int KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_stable,
  output logic                evt_valid,
  output logic [KW-1:0]       evt_key,
  output logic [1:0]          evt_type,
  input  logic                evt_ready,
  output logic [7:0]          drop_cnt
);

  localparam int CMAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
  localparam int CW   = $clog2(CMAX);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_DELAY - 1);
  localparam logic [CW-1:0] REP_LOAD  = CW'(REPEAT_PERIOD - 1);
  localparam logic [1:0] EVT_PRESS  = 2'b00;
  localparam logic [1:0] EVT_REPEAT = 2'b01;
`ifdef KEY_RELEASE_EVT_EN
  localparam logic [1:0] EVT_RELEASE = 2'b10;
`endif

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DELAY = 2'd1, S_REPEAT = 2'd2} state_t;

  logic                r_armed;
  logic [NUM_KEYS-1:0] r_key_prev;
  logic [NUM_KEYS-1:0] w_press, w_release;

  state_t              r_state     [NUM_KEYS];
  state_t              w_state_nxt [NUM_KEYS];
  logic [CW-1:0]       r_cnt       [NUM_KEYS];
  logic [CW-1:0]       w_cnt_nxt   [NUM_KEYS];
  logic [NUM_KEYS-1:0] w_gen;
  logic [1:0]          w_gen_type  [NUM_KEYS];

  logic [NUM_KEYS-1:0] r_pend_vld;
  logic [1:0]          r_pend_type [NUM_KEYS];
  logic [KW-1:0]       w_sel;
  logic                w_any, w_push, w_pop, w_full, w_empty;
  logic [NUM_KEYS-1:0] w_push_sel, w_drop;
  logic [7:0]          r_drop_cnt, w_drop_nxt;

  logic [KW+1:0]       r_mem [FIFO_DEPTH];
  logic [AW:0]         r_wr_ptr, r_rd_ptr;
  logic [KW+1:0]       w_head;

  // Edge detector; the first cycle after reset only captures levels so a key
  // held through reset does not look like a fresh press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_armed    <= 1'b0;
      r_key_prev <= '1;
    end else begin
      r_armed    <= 1'b1;
      r_key_prev <= key_stable;
    end
  end

  assign w_press   = r_armed ? (r_key_prev & ~key_stable) : '0;
  assign w_release = r_armed ? (~r_key_prev & key_stable) : '0;

  // Key FSM state and down-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        r_state[i] <= S_IDLE;
        r_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
    end
  end

  // Key FSM next state, counter update and event generation; release wins over
  // a terminal count in the same cycle.
  always_comb begin
    for (int i = 0; i < NUM_KEYS; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      w_gen[i]       = 1'b0;
      w_gen_type[i]  = EVT_PRESS;
      case (r_state[i])
        S_IDLE: begin
          if (w_press[i]) begin
            w_gen[i]       = 1'b1;
            w_gen_type[i]  = EVT_PRESS;
            w_cnt_nxt[i]   = HOLD_LOAD;
            w_state_nxt[i] = S_DELAY;
          end
        end
        S_DELAY, S_REPEAT: begin
          if (w_release[i]) begin
            w_state_nxt[i] = S_IDLE;
            w_cnt_nxt[i]   = '0;
`ifdef KEY_RELEASE_EVT_EN
            w_gen[i]       = 1'b1;
            w_gen_type[i]  = EVT_RELEASE;
`endif
          end else if (r_cnt[i] == '0) begin
            w_gen[i]       = 1'b1;
            w_gen_type[i]  = EVT_REPEAT;
            w_cnt_nxt[i]   = REP_LOAD;
            w_state_nxt[i] = S_REPEAT;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] - 1'b1;
          end
        end
        default: begin
          w_state_nxt[i] = S_IDLE;
          w_cnt_nxt[i]   = '0;
        end
      endcase
    end
  end

  // Lowest-index occupied slot wins the FIFO write port.
  always_comb begin
    w_sel = '0;
    w_any = |r_pend_vld;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (r_pend_vld[i]) w_sel = KW'(i);
    end
  end

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = ~w_empty & evt_ready;
  assign w_push  = w_any & (~w_full | w_pop);

  // A drop is a new event landing on a slot whose old event is not leaving
  // this cycle; the counter saturates.
  always_comb begin
    w_drop_nxt = r_drop_cnt;
    for (int i = 0; i < NUM_KEYS; i++) begin
      w_push_sel[i] = w_push && (w_sel == KW'(i));
      w_drop[i]     = w_gen[i] & r_pend_vld[i] & ~w_push_sel[i];
      if (w_drop[i] && (w_drop_nxt != 8'hFF)) w_drop_nxt = w_drop_nxt + 8'd1;
    end
  end

  // Pending slots and drop counter; a fresh event beats the clear from a push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_vld <= '0;
      r_drop_cnt <= '0;
      for (int i = 0; i < NUM_KEYS; i++) r_pend_type[i] <= EVT_PRESS;
    end else begin
      r_drop_cnt <= w_drop_nxt;
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (w_gen[i]) begin
          r_pend_vld[i]  <= 1'b1;
          r_pend_type[i] <= w_gen_type[i];
        end else if (w_push_sel[i]) begin
          r_pend_vld[i] <= 1'b0;
        end
      end
    end
  end

  // FIFO pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // FIFO storage; outputs are gated by empty so contents need no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {w_sel, r_pend_type[w_sel]};
  end

  assign w_head    = r_mem[r_rd_ptr[AW-1:0]];
  assign evt_valid = ~w_empty;
  assign evt_key   = w_empty ? '0 : w_head[KW+1:2];
  assign evt_type  = w_empty ? 2'b00 : w_head[1:0];
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_key_event_queue.sv
// Bench for key_event_queue: directed scenarios plus a randomized run, checked by a
// scoreboard of per-key expected event sequences derived from key hold times.
`timescale 1ns/1ps
module tb_key_event_queue;
  localparam int NK = 4;
  localparam int HD = 10;
  localparam int RP = 4;
  localparam int FD = 4;
`ifdef KEY_RELEASE_EVT_EN
  localparam int REL_EN = 1;
`else
  localparam int REL_EN = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] key_stable = '1;
  logic          evt_ready = 1'b1;
  logic          evt_valid;
  logic [1:0]    evt_key;
  logic [1:0]    evt_type;
  logic [7:0]    drop_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Scoreboard: per-key expected event types, totals, and a delivery log.
  int exp_q [NK][$];
  int gen_total = 0;
  int del_total = 0;
  int log_key [$];
  int log_typ [$];
  int log_cyc [$];

  key_event_queue #(
    .NUM_KEYS(NK), .HOLD_DELAY(HD), .REPEAT_PERIOD(RP), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .key_stable(key_stable),
    .evt_valid(evt_valid), .evt_key(evt_key), .evt_type(evt_type),
    .evt_ready(evt_ready), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: sampled at the negedge preceding each active edge. Events
  // follow from how long each key has been held since its press.
  logic [NK-1:0] m_prev;
  bit            m_armed = 0;
  bit            m_held [NK];
  int            m_t    [NK];
  always @(negedge clk) begin
    if (rst) begin
      m_armed = 0;
      gen_total = 0;
      for (int k = 0; k < NK; k++) begin
        exp_q[k].delete();
        m_held[k] = 0;
        m_t[k] = 0;
      end
    end else if (!m_armed) begin
      m_armed = 1;
      m_prev = key_stable;
    end else begin
      for (int k = 0; k < NK; k++) begin
        if (m_prev[k] && !key_stable[k]) begin
          exp_q[k].push_back(0);
          gen_total++;
          m_held[k] = 1;
          m_t[k] = 0;
        end else if (m_held[k] && key_stable[k]) begin
          m_held[k] = 0;
          if (REL_EN != 0) begin
            exp_q[k].push_back(2);
            gen_total++;
          end
        end else if (m_held[k]) begin
          m_t[k]++;
          if (m_t[k] == HD || (m_t[k] > HD && ((m_t[k] - HD) % RP) == 0)) begin
            exp_q[k].push_back(1);
            gen_total++;
          end
        end
      end
      m_prev = key_stable;
    end
  end

  // Monitor: every handshake must match the next surviving event of that key;
  // events skipped over are ones the DUT legitimately overwrote.
  always @(negedge clk) begin : monitor
    int  k;
    int  t;
    bit  found;
    if (rst) begin
      del_total = 0;
    end else if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
      k = int'(evt_key);
      t = int'(evt_type);
      found = 0;
      del_total++;
      log_key.push_back(k);
      log_typ.push_back(t);
      log_cyc.push_back(cyc);
      while (exp_q[k].size() > 0 && !found) begin
        if (exp_q[k][0] == t) found = 1;
        void'(exp_q[k].pop_front());
      end
      check("sb_event_match", {31'd0, found}, 32'd1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_key.delete();
    log_typ.delete();
    log_cyc.delete();
  endtask

  task automatic check_drained(input string name);
    int exp_drop;
    for (int k = 0; k < NK; k++) check({name, "_queue_empty"}, exp_q[k].size(), 0);
    exp_drop = gen_total - del_total;
    if (exp_drop > 255) exp_drop = 255;
    check({name, "_drop_cnt"}, drop_cnt, exp_drop);
  endtask

  initial begin
    int pc, lastc, nr, np, nrel, vhigh, nrep_fill;
    int exp_k [$];
    int exp_t [$];

    // Reset values
    #1;
    check("rst_valid", evt_valid, 0);
    check("rst_key", evt_key, 0);
    check("rst_type", evt_type, 0);
    check("rst_drop", drop_cnt, 0);
    tick(2);
    rst = 1'b0;
    tick(3);

    // Single press on key 2: valid exactly two edges after the level change, for one cycle
    key_stable[2] = 1'b0;
    check("lat_c0_valid", evt_valid, 0);
    tick(1);
    check("lat_c1_valid", evt_valid, 0);
    tick(1);
    check("lat_c2_valid", evt_valid, 1);
    check("lat_c2_key", evt_key, 2);
    check("lat_c2_type", evt_type, 0);
    tick(1);
    check("lat_c3_valid", evt_valid, 0);
    key_stable[2] = 1'b1;
    tick(8);

    // Hold key 0 for 25 cycles: PRESS, REPEAT after HD, then every RP
    clear_log();
    key_stable[0] = 1'b0;
    tick(25);
    key_stable[0] = 1'b1;
    tick(10);
    pc = 0; lastc = 0; nr = 0; np = 0; nrel = 0;
    for (int i = 0; i < log_key.size(); i++) begin
      if (log_key[i] == 0) begin
        if (log_typ[i] == 0) begin
          pc = log_cyc[i];
          np++;
        end else if (log_typ[i] == 1) begin
          if (nr == 0) check("first_repeat_delay", log_cyc[i] - pc, HD);
          else         check("repeat_period", log_cyc[i] - lastc, RP);
          lastc = log_cyc[i];
          nr++;
        end else if (log_typ[i] == 2) begin
          nrel++;
        end
      end
    end
    check("hold_press_count", np, 1);
    check("hold_repeat_count", nr, 4);
    check("hold_release_count", nrel, REL_EN);
    check_drained("hold");

    // Keys 1 and 3 pressed together: lower index first
    key_stable[1] = 1'b0;
    key_stable[3] = 1'b0;
    tick(2);
    check("tie_first_valid", evt_valid, 1);
    check("tie_first_key", evt_key, 1);
    check("tie_first_type", evt_type, 0);
    tick(1);
    check("tie_second_valid", evt_valid, 1);
    check("tie_second_key", evt_key, 3);
    check("tie_second_type", evt_type, 0);
    tick(1);
    check("tie_after_valid", evt_valid, 0);
    key_stable[1] = 1'b1;
    key_stable[3] = 1'b1;
    tick(8);

    // Backpressure: FIFO fills, remaining events wait in slots without loss
    evt_ready = 1'b0;
    for (int k = 0; k < NK; k++) begin
      key_stable[k] = 1'b0;
      tick(1);
    end
    for (int k = 0; k < NK; k++) begin
      key_stable[k] = 1'b1;
      tick(1);
    end
    tick(4);
    check("bp_valid_held", evt_valid, 1);
    check("bp_head_key", evt_key, 0);
    check("bp_drop_zero", drop_cnt, 0);
    clear_log();
    evt_ready = 1'b1;
    tick(14);
    for (int k = 0; k < NK; k++) begin
      exp_k.push_back(k);
      exp_t.push_back(0);
    end
    if (REL_EN != 0) begin
      for (int k = 0; k < NK; k++) begin
        exp_k.push_back(k);
        exp_t.push_back(2);
      end
    end
    check("bp_delivered_count", log_key.size(), exp_k.size());
    for (int i = 0; i < exp_k.size() && i < log_key.size(); i++) begin
      check("bp_order_key", log_key[i], exp_k[i]);
      check("bp_order_type", log_typ[i], exp_t[i]);
    end
    check_drained("bp");

    // Overwrite: FIFO full, key 0 press then release while waiting in its slot
    evt_ready = 1'b0;
    nrep_fill = (REL_EN != 0) ? 2 : 4;
    for (int r = 0; r < nrep_fill; r++) begin
      key_stable[1] = 1'b0;
      tick(2);
      key_stable[1] = 1'b1;
      tick(2);
    end
    tick(2);
    check("ovw_fifo_full_valid", evt_valid, 1);
    key_stable[0] = 1'b0;
    tick(3);
    key_stable[0] = 1'b1;
    tick(3);
    check("ovw_drop_cnt", drop_cnt, REL_EN);
    evt_ready = 1'b1;
    tick(12);
    check_drained("ovw");

    // Reset mid-DELAY with key 1 held: everything clears, no events afterwards
    evt_ready = 1'b0;
    key_stable[1] = 1'b0;
    tick(4);
    check("mrst_pre_valid", evt_valid, 1);
    rst = 1'b1;
    #1;
    check("mrst_valid", evt_valid, 0);
    check("mrst_key", evt_key, 0);
    check("mrst_type", evt_type, 0);
    check("mrst_drop", drop_cnt, 0);
    tick(1);
    rst = 1'b0;
    evt_ready = 1'b1;
    clear_log();
    vhigh = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (evt_valid !== 1'b0) vhigh++;
    end
    key_stable[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (evt_valid !== 1'b0) vhigh++;
    end
    check("mrst_no_valid_cycles", vhigh, 0);
    check("mrst_no_events", log_key.size(), 0);
    check("mrst_drop_after", drop_cnt, 0);

    // Randomized key activity with random consumer stalls
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < NK; k++) begin
        if ($urandom_range(0, 7) == 0) key_stable[k] = ~key_stable[k];
      end
      evt_ready = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    key_stable = '1;
    evt_ready = 1'b1;
    tick(40);
    check("rand_valid_idle", evt_valid, 0);
    check_drained("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
